// File: rtl/imm_gen_pipe_pkg.sv
// imm_pkg: opcode encodings, decode formats and the pipeline entry layout
// shared by the immediate generator and its users.
package imm_pkg;

    localparam int unsigned IMM_WIDTH_DEF = 32;
    localparam int unsigned LANES_DEF     = 4;
    localparam int unsigned TAG_WIDTH_DEF = 4;

    // Opcodes are written MSB first: bit [4] of the port is opcode index 0.
    localparam logic [4:0] OP_ZX_A  = 5'b11000;
    localparam logic [4:0] OP_ZX_B  = 5'b10010;
    localparam logic [4:0] OP_SX17  = 5'b01000;
    localparam logic [4:0] OP_SX12B = 5'b11001;
    localparam logic [4:0] OP_SX15  = 5'b00100;

    typedef enum logic [2:0] {
        FMT_ZX10,
        FMT_SX17,
        FMT_SX12B,
        FMT_SX15,
        FMT_NONE
    } imm_fmt_e;

    // Entry layout for the default configuration (IMM_WIDTH=32, LANES=4, TAG_WIDTH=4).
    typedef struct packed {
        logic [IMM_WIDTH_DEF-1:0]           imm;
        logic [LANES_DEF*IMM_WIDTH_DEF-1:0] lanes;
        logic [TAG_WIDTH_DEF-1:0]           tag;
        logic                               illegal;
    } imm_entry_t;

    function automatic imm_fmt_e opcode_fmt(input logic [4:0] op);
        imm_fmt_e fmt;
        case (op)
            OP_ZX_A, OP_ZX_B: fmt = FMT_ZX10;
            OP_SX17:          fmt = FMT_SX17;
            OP_SX12B:         fmt = FMT_SX12B;
            OP_SX15:          fmt = FMT_SX15;
            default:          fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle of imm_gen_pipe.
// master: fetch side plus downstream consumer; slave: the generator.
interface imm_gen_pipe_if #(
    parameter int unsigned IMM_WIDTH = 32,
    parameter int unsigned LANES     = 4,
    parameter int unsigned TAG_WIDTH = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [4:0]                 opcode;
    logic [14:0]                instr_p1;
    logic [9:0]                 instr_p2;
    logic                       lane_mode;
    logic [TAG_WIDTH-1:0]       in_tag;
    logic                       out_valid;
    logic                       out_ready;
    logic [IMM_WIDTH-1:0]       imm;
    logic [LANES*IMM_WIDTH-1:0] imm_vec;
    logic [TAG_WIDTH-1:0]       out_tag;
    logic                       illegal;

    modport master (
        output in_valid, opcode, instr_p1, instr_p2, lane_mode, in_tag, out_ready,
        input  in_ready, out_valid, imm, imm_vec, out_tag, illegal
    );

    modport slave (
        input  in_valid, opcode, instr_p1, instr_p2, lane_mode, in_tag, out_ready,
        output in_ready, out_valid, imm, imm_vec, out_tag, illegal
    );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: combinational format select and sign/zero extension.
// Fields are MSB-first: field index i maps to port bit (width-1-i).
// Optional illegal_o port exists only with IMMGEN_ILLEGAL_FLAG_EN.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned IMM_WIDTH = 32
) (
    input  logic [4:0]           opcode_i,
    input  logic [14:0]          p1_i,
    input  logic [9:0]           p2_i,
    output logic [IMM_WIDTH-1:0] imm_o
`ifdef IMMGEN_ILLEGAL_FLAG_EN
    ,
    output logic                 illegal_o
`endif
);

    imm_fmt_e    fmt;
    logic [16:0] sx17;
    logic [11:0] sx12;

    assign fmt  = opcode_fmt(opcode_i);
    // {P1[0:6], P2}
    assign sx17 = {p1_i[14:8], p2_i};
    // {P1[0], P2[4], P1[1:6], P2[0:3]}
    assign sx12 = {p1_i[14], p2_i[5], p1_i[13:8], p2_i[9:6]};

    // Extend the selected field to the full immediate width.
    always_comb begin
        imm_o = '0;
        case (fmt)
            FMT_ZX10:  imm_o = IMM_WIDTH'(p2_i);
            FMT_SX17:  imm_o = IMM_WIDTH'($signed(sx17));
            FMT_SX12B: imm_o = IMM_WIDTH'($signed(sx12));
            FMT_SX15:  imm_o = IMM_WIDTH'($signed(p1_i));
            default:   imm_o = '0;
        endcase
    end

`ifdef IMMGEN_ILLEGAL_FLAG_EN
    assign illegal_o = (fmt == FMT_NONE);
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with lane expansion,
// registered output and a one-entry skid buffer.
// Optional feature macro: IMMGEN_ILLEGAL_FLAG_EN (registered illegal flag
// plus saturating illegal_count debug output).
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned IMM_WIDTH = IMM_WIDTH_DEF,
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned TAG_WIDTH = TAG_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
`ifdef IMMGEN_ILLEGAL_FLAG_EN
    ,
    output logic [7:0]    illegal_count
`endif
);

    typedef struct packed {
        logic [IMM_WIDTH-1:0]       imm;
        logic [LANES*IMM_WIDTH-1:0] lanes;
        logic [TAG_WIDTH-1:0]       tag;
        logic                       illegal;
    } entry_t;

    entry_t               dec_entry;
    entry_t               out_q, out_d;
    entry_t               skid_q, skid_d;
    logic                 out_valid_q, out_valid_d;
    logic                 skid_full_q, skid_full_d;
    logic                 in_fire;
    logic                 out_free;
    logic [IMM_WIDTH-1:0] dec_imm;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
    logic                 dec_illegal;
    logic [7:0]           illegal_count_q;
`endif

    imm_decode #(
        .IMM_WIDTH (IMM_WIDTH)
    ) u_decode (
        .opcode_i  (bus.opcode),
        .p1_i      (bus.instr_p1),
        .p2_i      (bus.instr_p2),
        .imm_o     (dec_imm)
`ifdef IMMGEN_ILLEGAL_FLAG_EN
        ,
        .illegal_o (dec_illegal)
`endif
    );

    // Build the entry for the incoming instruction, expanding the lanes.
    always_comb begin
        dec_entry.imm   = dec_imm;
        dec_entry.tag   = bus.in_tag;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
        dec_entry.illegal = dec_illegal;
`else
        dec_entry.illegal = 1'b0;
`endif
        dec_entry.lanes = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            dec_entry.lanes[k*IMM_WIDTH +: IMM_WIDTH] =
                dec_imm + (bus.lane_mode ? IMM_WIDTH'(k) : '0);
        end
    end

    // A full skid blocks input, so skid->output moves never race a new entry.
    assign in_fire  = bus.in_valid && !skid_full_q && !flush;
    assign out_free = !out_valid_q || bus.out_ready;

    // Next-state for the output register and the skid buffer.
    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;
        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (out_free) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end else if (in_fire) begin
                out_d       = dec_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d      = dec_entry;
            skid_full_d = 1'b1;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
        end
    end

`ifdef IMMGEN_ILLEGAL_FLAG_EN
    // Count illegal entries as they leave, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_count_q <= '0;
        end else if (out_valid_q && bus.out_ready && out_q.illegal && (illegal_count_q != 8'hFF)) begin
            illegal_count_q <= illegal_count_q + 8'd1;
        end
    end

    assign illegal_count = illegal_count_q;
`endif

    assign bus.in_ready  = !skid_full_q;
    assign bus.out_valid = out_valid_q;
    assign bus.imm       = out_q.imm;
    assign bus.imm_vec   = out_q.lanes;
    assign bus.out_tag   = out_q.tag;
    assign bus.illegal   = out_q.illegal;

endmodule
